// File: rtl/conv_seq_pkg.sv
// Shared encodings for the converter start-up sequencer: FSM state codes and gate masks.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StPrecharge = 3'd1,
    StSoftstart = 3'd2,
    StRun       = 3'd3,
    StFault     = 3'd4
  } state_e;

  // Gate order is {Q4,Q3,Q2,Q1}; precharge turns on both low sides.
  localparam logic [3:0] GatePrecharge = 4'b1100;
  localparam logic [3:0] GateOff       = 4'b0000;

  // A leg conducts straight through when both of its switches are on.
  function automatic logic is_shoot_through(input logic [3:0] gate);
    return (gate[0] & gate[2]) | (gate[1] & gate[3]);
  endfunction

endpackage

// File: rtl/converter_sequencer_phi_ramp.sv
// Soft-start phi step generator: divider plus saturating step of phi toward a target.
module phi_ramp #(
  parameter int unsigned RAMP_DIV = 100,
  parameter int signed   PHI_STEP = 32'sd1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic signed [31:0] phi,
  input  logic signed [31:0] target,
  output logic               step,
  output logic signed [31:0] phi_next
);

  logic        [31:0] div_q, div_d;
  logic signed [33:0] diff;
  logic signed [33:0] mag;

  assign step = ({1'b0, div_q} + 33'd1) >= {1'b0, RAMP_DIV};

  always_comb begin
    div_d = div_q;
    if (clear || step) begin
      div_d = '0;
    end else if (div_q != '1) begin
      div_d = div_q + 32'd1;
    end
  end

  // Widened difference so extreme targets cannot overflow the distance check.
  always_comb begin
    diff     = {target[31], target[31], target} - {phi[31], phi[31], phi};
    mag      = diff[33] ? -diff : diff;
    phi_next = phi;
    if (step) begin
      if (mag <= 34'(PHI_STEP)) begin
        phi_next = target;
      end else if (diff[33]) begin
        phi_next = phi - PHI_STEP;
      end else begin
        phi_next = phi + PHI_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/converter_sequencer.sv
// Power-stage start-up sequencer: IDLE -> PRECHARGE -> [SOFTSTART] -> RUN, latched FAULT.
// Define CONVERTER_SEQUENCER_SOFTSTART_EN to build the SOFTSTART phi ramp.
module converter_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned PRECHARGE_CYCLES = 1000,
  parameter int unsigned RAMP_DIV         = 100,
  parameter int signed   PHI_START        = 32'sd10,
  parameter int signed   PHI_STEP         = 32'sd1
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic               i_enable,
  input  logic               i_fault,
  input  logic               i_fault_clear,
  input  logic [3:0]         i_MOSFET,
  input  logic signed [31:0] i_phi_target,
  output logic [3:0]         o_MOSFET,
  output logic signed [31:0] o_phi,
  output logic               o_on,
  output logic [2:0]         o_state,
  output logic               o_fault
);

  state_e             state_q, state_d;
  logic        [31:0] cnt_q, cnt_d;
  logic        [3:0]  mosfet_q, mosfet_d;
  logic signed [31:0] phi_q, phi_d;
  logic               on_q, on_d;
  logic               fault_q, fault_d;
  logic               pre_done;
  logic               shoot;

  assign pre_done = ({1'b0, cnt_q} + 33'd1) >= {1'b0, PRECHARGE_CYCLES};
  assign shoot    = is_shoot_through(i_MOSFET);

`ifdef CONVERTER_SEQUENCER_SOFTSTART_EN
  localparam state_e StAfterPrecharge = StSoftstart;

  logic               ramp_step;
  logic signed [31:0] ramp_phi;

  phi_ramp #(
    .RAMP_DIV (RAMP_DIV),
    .PHI_STEP (PHI_STEP)
  ) u_phi_ramp (
    .clk      (i_clock),
    .rst_n    (i_RESET),
    .clear    (state_q != StSoftstart),
    .phi      (phi_q),
    .target   (i_phi_target),
    .step     (ramp_step),
    .phi_next (ramp_phi)
  );
`else
  localparam state_e StAfterPrecharge = StRun;
`endif

  // Fault and shoot-through outrank an enable drop, which outranks timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (i_enable && !fault_q) state_d = StPrecharge;
      end
      StPrecharge: begin
        if (i_fault) begin
          state_d = StFault;
        end else if (!i_enable) begin
          state_d = StIdle;
        end else if (pre_done) begin
          state_d = StAfterPrecharge;
        end
      end
`ifdef CONVERTER_SEQUENCER_SOFTSTART_EN
      StSoftstart: begin
        if (i_fault || shoot) begin
          state_d = StFault;
        end else if (!i_enable) begin
          state_d = StIdle;
        end else if (ramp_phi == i_phi_target) begin
          state_d = StRun;
        end
      end
`endif
      StRun: begin
        if (i_fault || shoot) begin
          state_d = StFault;
        end else if (!i_enable) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        if (i_fault_clear && !i_enable && !i_fault) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_comb begin
    mosfet_d = GateOff;
    phi_d    = PHI_START;
    on_d     = (state_d == StRun);
    fault_d  = (state_d == StFault);
    case (state_d)
      StPrecharge:        mosfet_d = GatePrecharge;
      StSoftstart, StRun: mosfet_d = shoot ? GateOff : i_MOSFET;
      default:            mosfet_d = GateOff;
    endcase
    if (state_d == StRun) begin
      phi_d = i_phi_target;
    end
`ifdef CONVERTER_SEQUENCER_SOFTSTART_EN
    else if (state_d == StSoftstart && state_q == StSoftstart) begin
      phi_d = ramp_phi;
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mosfet_q <= GateOff;
      phi_q    <= PHI_START;
      on_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mosfet_q <= mosfet_d;
      phi_q    <= phi_d;
      on_q     <= on_d;
      fault_q  <= fault_d;
    end
  end

  assign o_MOSFET = mosfet_q;
  assign o_phi    = phi_q;
  assign o_on     = on_q;
  assign o_state  = state_q;
  assign o_fault  = fault_q;

endmodule
